// File: rtl/paralelo_serial_tx.sv
// Byte-to-serial transmitter, MSB first, one bit per clk_32f edge.
// Sends a comma preamble after reset, then data bytes with comma fill on underflow.
module paralelo_serial_tx #(
   parameter logic [7:0]  COMMA       = 8'hBC,
   parameter int unsigned COMMA_COUNT = 4
) (
   input  logic       clk_32f,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       valid_in,
   output logic       ready_out,
   output logic       data_out,
   output logic       active_out,
   output logic       sync_done
);

   typedef enum logic {SYNC, ACTIVE} state_t;

   localparam logic [3:0] COMMA_LAST = 4'(COMMA_COUNT);

   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] cur_byte_q, cur_byte_d;
   logic       cur_is_data_q, cur_is_data_d;
   logic [7:0] hold_data_q, hold_data_d;
   logic       hold_valid_q, hold_valid_d;
   logic [3:0] comma_cnt_q, comma_cnt_d;
   logic       sync_done_q, sync_done_d;
   logic       data_out_q, data_out_d;
   logic       active_out_q, active_out_d;

   logic boundary;
   logic accept;
   logic consume;

   assign boundary  = (bit_cnt_q == 3'd7);
   assign ready_out = sync_done_q & (~hold_valid_q | boundary);
   assign accept    = valid_in & ready_out;
   assign consume   = boundary & (state_q == ACTIVE) & hold_valid_q;

   assign data_out   = data_out_q;
   assign active_out = active_out_q;
   assign sync_done  = sync_done_q;

   always_ff @(posedge clk_32f or posedge reset) begin
      if (reset) begin
         state_q       <= SYNC;
         bit_cnt_q     <= 3'd0;
         cur_byte_q    <= COMMA;
         cur_is_data_q <= 1'b0;
         hold_data_q   <= 8'h00;
         hold_valid_q  <= 1'b0;
         comma_cnt_q   <= 4'd0;
         sync_done_q   <= 1'b0;
         data_out_q    <= 1'b0;
         active_out_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         cur_byte_q    <= cur_byte_d;
         cur_is_data_q <= cur_is_data_d;
         hold_data_q   <= hold_data_d;
         hold_valid_q  <= hold_valid_d;
         comma_cnt_q   <= comma_cnt_d;
         sync_done_q   <= sync_done_d;
         data_out_q    <= data_out_d;
         active_out_q  <= active_out_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q + 3'd1;
      cur_byte_d    = cur_byte_q;
      cur_is_data_d = cur_is_data_q;
      hold_data_d   = hold_data_q;
      hold_valid_d  = hold_valid_q;
      comma_cnt_d   = comma_cnt_q;
      sync_done_d   = sync_done_q;
      data_out_d    = cur_byte_q[3'd7 - bit_cnt_q];
      active_out_d  = cur_is_data_q;

      // A byte is only ever swapped in whole, at the last bit of the previous one.
      if (boundary) begin
         if (consume) begin
            cur_byte_d    = hold_data_q;
            cur_is_data_d = 1'b1;
            hold_valid_d  = 1'b0;
         end else begin
            cur_byte_d    = COMMA;
            cur_is_data_d = 1'b0;
         end
      end

      if (accept) begin
         hold_data_d  = data_in;
         hold_valid_d = 1'b1;
      end

      case (state_q)
         SYNC: begin
            if (boundary) begin
               comma_cnt_d = comma_cnt_q + 4'd1;
               if (comma_cnt_q + 4'd1 == COMMA_LAST) begin
                  state_d     = ACTIVE;
                  sync_done_d = 1'b1;
               end
            end
         end
         ACTIVE: begin
            state_d = ACTIVE;
         end
         default: begin
            state_d = SYNC;
         end
      endcase
   end

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Randomized bench for paralelo_serial_tx against a slot-level model of the serial line.
module tb_paralelo_serial_tx;

   localparam logic [7:0] COMMA = 8'hBC;

   logic       clk_32f = 1'b0;
   logic       reset   = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       valid_in = 1'b0;
   logic       ready_out, data_out, active_out, sync_done;

   paralelo_serial_tx #(.COMMA(8'hBC), .COMMA_COUNT(4)) dut (
      .clk_32f    (clk_32f),
      .reset      (reset),
      .data_in    (data_in),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .data_out   (data_out),
      .active_out (active_out),
      .sync_done  (sync_done)
   );

   always #5 clk_32f = ~clk_32f;

   int tests = 0;
   int fails = 0;

   // Model: the line is a sequence of 8-edge slots, each a whole byte.
   logic [7:0] slot_byte[$];
   logic       slot_data[$];
   logic [7:0] hold_q[$];
   int         edge_n;
   logic       exp_ready, exp_dout, exp_act, exp_sync;
   logic       obs_ready, accepted;

   task automatic model_reset();
      slot_byte.delete();
      slot_data.delete();
      hold_q.delete();
      slot_byte.push_back(COMMA);
      slot_data.push_back(1'b0);
      edge_n = 0;
   endtask

   task automatic tick(input logic v, input logic [7:0] d);
      int m;
      logic [7:0] b;
      exp_ready = (edge_n >= 32) && ((hold_q.size() == 0) || (edge_n % 8 == 7));
      accepted  = v && exp_ready;
      valid_in  = v;
      data_in   = d;
      #1;
      obs_ready = ready_out;
      @(posedge clk_32f);
      #1;
      edge_n++;
      m = edge_n;
      b = slot_byte[(m - 1) / 8];
      exp_dout = b[7 - ((m - 1) % 8)];
      exp_act  = slot_data[(m - 1) / 8];
      exp_sync = (m >= 32);
      if (m % 8 == 0) begin
         if (m > 32 && hold_q.size() > 0) begin
            slot_byte.push_back(hold_q.pop_front());
            slot_data.push_back(1'b1);
         end else begin
            slot_byte.push_back(COMMA);
            slot_data.push_back(1'b0);
         end
      end
      if (accepted) begin
         hold_q.push_back(d);
         $display("[TB] edge %0d accept byte 0x%02h", m, d);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1;
      tests++;
      if ({data_out, active_out, sync_done, ready_out} !== 4'b0000) begin
         fails++;
         $display("FAIL reset_outputs got d/a/s/r=%b need 0000",
                  {data_out, active_out, sync_done, ready_out});
      end
      @(posedge clk_32f);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_sync();
      for (int i = 0; i < 40; i++) begin
         tick(1'b0, 8'h00);
         tests++;
         if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
            fails++;
            $display("FAIL sync edge=%0d got r/d/a/s=%b need %b", edge_n,
                     {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
         end
      end
   endtask

   task automatic test_single();
      tick(1'b1, 8'hA5);
      tests++;
      if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
         fails++;
         $display("FAIL single_accept edge=%0d got r/d/a/s=%b need %b", edge_n,
                  {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
      end
      for (int i = 0; i < 30; i++) begin
         tick(1'b0, 8'h00);
         tests++;
         if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
            fails++;
            $display("FAIL single edge=%0d got r/d/a/s=%b need %b", edge_n,
                     {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  seq [3];
      logic [23:0] run;
      int          run_len, k;
      bit          done;
      seq[0] = 8'h00; seq[1] = 8'hFF; seq[2] = 8'h3C;
      run = '0; run_len = 0; k = 0; done = 0;
      for (int i = 0; i < 70; i++) begin
         if (k < 3) tick(1'b1, seq[k]);
         else       tick(1'b0, 8'h00);
         if (accepted) k++;
         tests++;
         if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
            fails++;
            $display("FAIL b2b edge=%0d got r/d/a/s=%b need %b", edge_n,
                     {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
         end
         if (!done && active_out === 1'b1) begin
            run = {run[22:0], data_out};
            run_len++;
         end else if (run_len > 0) begin
            done = 1;
         end
      end
      tests++;
      if (run_len != 24 || run !== 24'h00FF3C) begin
         fails++;
         $display("FAIL b2b_stream got len=%0d bits=%06h need len=24 bits=00ff3c", run_len, run);
      end
   endtask

   task automatic test_hold_full();
      // Park on a non-boundary edge with the hold register empty.
      while (edge_n % 8 != 2) tick(1'b0, 8'h00);
      tick(1'b1, 8'h5A);
      tests++;
      if (obs_ready !== 1'b1 || exp_ready !== 1'b1) begin
         fails++;
         $display("FAIL hold_first_accept got ready=%b need 1", obs_ready);
      end
      // Blocked edges offer a decoy byte; the boundary edge offers the real one.
      for (int i = 0; i < 30; i++) begin
         if (edge_n % 8 == 7 && i < 8) tick(1'b1, 8'hC3);
         else if (i < 8)               tick(1'b1, 8'h11);
         else                          tick(1'b0, 8'h00);
         tests++;
         if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
            fails++;
            $display("FAIL hold_full edge=%0d got r/d/a/s=%b need %b", edge_n,
                     {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] pend;
      logic       have;
      pend = 8'($urandom);
      have = 1'b1;
      for (int i = 0; i < 600; i++) begin
         tick(have, pend);
         if (accepted) begin
            pend = 8'($urandom);
            have = ($urandom_range(0, 3) != 0);
         end else if (!have) begin
            have = ($urandom_range(0, 2) == 0);
         end
         tests++;
         if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
            fails++;
            $display("FAIL random edge=%0d got r/d/a/s=%b need %b", edge_n,
                     {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
         end
      end
   endtask

   task automatic test_reset_mid();
      int guard;
      guard = 0;
      // Stream data until the line shows bit 4 of a data byte with a byte held.
      while (!(exp_act && ((edge_n - 1) % 8 == 4) && hold_q.size() > 0) && guard < 200) begin
         tick(1'b1, 8'($urandom));
         guard++;
      end
      tests++;
      if (guard >= 200) begin
         fails++;
         $display("FAIL reset_mid_setup got timeout=%0d need <200", guard);
      end
      test_reset();
      for (int i = 0; i < 56; i++) begin
         tick(1'b0, 8'h00);
         tests++;
         if ({obs_ready, data_out, active_out, sync_done} !== {exp_ready, exp_dout, exp_act, exp_sync}) begin
            fails++;
            $display("FAIL reset_mid edge=%0d got r/d/a/s=%b need %b", edge_n,
                     {obs_ready, data_out, active_out, sync_done}, {exp_ready, exp_dout, exp_act, exp_sync});
         end
      end
   endtask

   initial begin
      model_reset();
      #2;
      test_reset();
      test_sync();
      test_single();
      test_back_to_back();
      test_hold_full();
      test_random();
      test_reset_mid();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
